// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit scheduler.
//   - scheduler state encoding (3-bit) and its enum type
//   - default inter-frame gap and busy-timeout values
//   - cnt_width(): width of a counter that must hold 0..max_val
package uart_pkg;

  localparam logic [2:0] ENC_IDLE      = 3'd0;
  localparam logic [2:0] ENC_LAUNCH    = 3'd1;
  localparam logic [2:0] ENC_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ENC_WAIT_DONE = 3'd3;
  localparam logic [2:0] ENC_GAP       = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = ENC_IDLE,
    ST_LAUNCH    = ENC_LAUNCH,
    ST_WAIT_BUSY = ENC_WAIT_BUSY,
    ST_WAIT_DONE = ENC_WAIT_DONE,
    ST_GAP       = ENC_GAP
  } sched_state_e;

  localparam int DEF_GAP_CYCLES   = 16;
  localparam int DEF_BUSY_TIMEOUT = 1023;

  // A counter for 0..max_val; never narrower than one bit so that a
  // disabled feature (max_val == 0) still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req         in  NUM_REQ  request vector
//   rr_ptr      in  IDX_W    index of the last winner
//   grant_valid out 1        at least one request is set
//   grant_idx   out IDX_W    first set request at or after rr_ptr+1, wrapping
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down to +1, so the nearest set request
  // after the pointer is the last one written and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one 8N1 transmitter among NUM_REQ byte sources.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | sample req, grant round-robin winner, ack it, latch byte
//   LAUNCH    | issue tx_start, clear busy-timeout counter
//   WAIT_BUSY | wait for tx_busy to rise; error pulse after BUSY_TIMEOUT
//   WAIT_DONE | transmitter sending; wait for tx_busy to fall
//   GAP       | GAP_CYCLES idle cycles before the next arbitration
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   req         in   per-requester level request
//   req_data    in   byte of requester i in [8i+7:8i]
//   ack         out  one-cycle accept pulse per requester
//   tx_start    out  one-cycle launch strobe
//   tx_data     out  byte for the transmitter, held until the next grant
//   tx_busy     in   transmitter busy
//   grant_id    out  current/last granted requester
//   active      out  scheduler not idle
//   err_timeout out  one-cycle pulse when tx_busy never rose
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam int TO_W  = cnt_width(BUSY_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(BUSY_TIMEOUT);

  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               err_q, err_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (req),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = 1'b0;
    gap_cnt_d  = gap_cnt_q;
    to_cnt_d   = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          grant_id_d = grant_idx;
          rr_ptr_d   = grant_idx;
          tx_data_d  = req_data[{grant_idx, 3'b000} +: 8];
          ack_d      = NUM_REQ'(1) << grant_idx;
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_start_d = 1'b1;
        to_cnt_d   = '0;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // Compare before increment so the counter never wraps.
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_q == TO_LIMIT) begin
          err_d     = 1'b1;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (GAP_CYCLES == 0 || gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first
      err_q      <= 1'b0;
      gap_cnt_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
      gap_cnt_q  <= gap_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign ack         = ack_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign active      = (state_q != ST_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler. dut_a uses the default gap (16) and timeout
// (1023); dut_b is built with no inter-frame gap. Each DUT has a small
// transmitter model that raises tx_busy 3 cycles after tx_start for 20 cycles.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [3:0]  req_a = '0, req_b = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic [3:0]  ack_a, ack_b;
  logic        tx_start_a, tx_start_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_busy_a = 1'b0, tx_busy_b = 1'b0;
  logic [1:0]  gid_a, gid_b;
  logic        active_a, active_b, err_a, err_b;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(16), .BUSY_TIMEOUT(1023)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .req_data(data_a), .ack(ack_a),
    .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_busy(tx_busy_a),
    .grant_id(gid_a), .active(active_a), .err_timeout(err_a));

  uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(0), .BUSY_TIMEOUT(1023)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .req_data(data_b), .ack(ack_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_busy(tx_busy_b),
    .grant_id(gid_b), .active(active_b), .err_timeout(err_b));

  // Transmitter models: driven just after each rising edge.
  int   m_a = 0, m_b = 0;
  logic model_en_a = 1'b1;
  always @(posedge clk) begin
    #1;
    if (!reset || !model_en_a) m_a = 0;
    else if (tx_start_a)       m_a = 1;
    else if (m_a != 0)         m_a = (m_a >= 22) ? 0 : m_a + 1;
    tx_busy_a = (m_a >= 3);
  end
  always @(posedge clk) begin
    #1;
    if (!reset)          m_b = 0;
    else if (tx_start_b) m_b = 1;
    else if (m_b != 0)   m_b = (m_b >= 22) ? 0 : m_b + 1;
    tx_busy_b = (m_b >= 3);
  end

  int checks = 0, errors = 0, cyc = 0;

  // Scoreboard: expectations pushed with stimulus, observations from tick().
  int         exp_id[$];
  logic [7:0] exp_data[$];
  logic [3:0] obs_ack[$];
  int         obs_ack_cyc[$];
  logic [1:0] obs_gid[$];
  logic [7:0] obs_data[$];
  int         obs_start_cyc[$];
  logic [3:0] obs_ack_b[$];
  int         obs_ack_cyc_b[$];
  int         err_cnt, err_cyc, busy_fall_a, act_fall_a, busy_fall_b;
  logic       busy_prev_a, act_prev_a, busy_prev_b;
  logic       drop_a = 1'b0, drop_b = 1'b0;

  task automatic clear_obs();
    obs_ack.delete(); obs_ack_cyc.delete(); obs_gid.delete();
    obs_data.delete(); obs_start_cyc.delete();
    obs_ack_b.delete(); obs_ack_cyc_b.delete();
    exp_id.delete(); exp_data.delete();
    err_cnt = 0; err_cyc = -1; busy_fall_a = -1; act_fall_a = -1; busy_fall_b = -1;
  endtask

  // Advance to the next falling edge and record DUT events; requesters with
  // drop enabled release their request once acked.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ack_a != 4'h0) begin
      obs_ack.push_back(ack_a); obs_ack_cyc.push_back(cyc); obs_gid.push_back(gid_a);
      if (drop_a) req_a = req_a & ~ack_a;
    end
    if (tx_start_a) begin obs_data.push_back(tx_data_a); obs_start_cyc.push_back(cyc); end
    if (err_a) begin err_cnt++; err_cyc = cyc; end
    if (busy_prev_a && !tx_busy_a) busy_fall_a = cyc;
    if (act_prev_a && !active_a) act_fall_a = cyc;
    busy_prev_a = tx_busy_a; act_prev_a = active_a;
    if (ack_b != 4'h0) begin
      obs_ack_b.push_back(ack_b); obs_ack_cyc_b.push_back(cyc);
      if (drop_b) req_b = req_b & ~ack_b;
    end
    if (busy_prev_b && !tx_busy_b) busy_fall_b = cyc;
    busy_prev_b = tx_busy_b;
  endtask

  task automatic apply_reset();
    reset = 1'b0; req_a = '0; req_b = '0;
    tick(); tick();
    clear_obs();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({ack_a, tx_start_a, tx_data_a, gid_a, active_a, err_a} !== 17'h0) begin
      errors++; $display("FAIL reset_outputs_a got %h exp 0", {ack_a, tx_start_a, tx_data_a, gid_a, active_a, err_a});
    end
    checks++;
    if ({ack_b, tx_start_b, tx_data_b, gid_b, active_b, err_b} !== 17'h0) begin
      errors++; $display("FAIL reset_outputs_b got %h exp 0", {ack_b, tx_start_b, tx_data_b, gid_b, active_b, err_b});
    end
    clear_obs();
    reset = 1'b1;
    repeat (4) tick();
    checks++;
    if (active_a !== 1'b0 || obs_ack.size() != 0) begin
      errors++; $display("FAIL reset_idle got active=%b acks=%0d exp active=0 acks=0", active_a, obs_ack.size());
    end
  endtask

  task automatic test_single();
    int e_id, sa, ss; logic [3:0] o_ack; logic [1:0] o_gid; logic [7:0] e_d, o_d; bit to;
    apply_reset();
    drop_a = 1'b1; data_a = 32'h0000_A500;
    exp_id.push_back(1); exp_data.push_back(8'hA5);
    req_a = 4'b0010;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (obs_data.size() >= 1 && !active_a) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin errors++; $display("FAIL single_wait got timeout exp completion"); end
    sa = (obs_ack_cyc.size() != 0) ? obs_ack_cyc[0] : -100;
    ss = (obs_start_cyc.size() != 0) ? obs_start_cyc[0] : -200;
    checks++;
    if (ss - sa != 1) begin errors++; $display("FAIL single_ack_to_start got %0d exp 1", ss - sa); end
    // tx_busy changes just after an edge; the DUT first sees it low one
    // edge later, and the gap runs GAP_CYCLES edges from there.
    checks++;
    if (act_fall_a - busy_fall_a != 17) begin
      errors++; $display("FAIL single_gap got %0d exp 17", act_fall_a - busy_fall_a);
    end
    while (exp_id.size() != 0) begin
      e_id = exp_id.pop_front(); e_d = exp_data.pop_front();
      o_ack = (obs_ack.size() != 0) ? obs_ack.pop_front() : 4'h0;
      o_gid = (obs_gid.size() != 0) ? obs_gid.pop_front() : 2'bxx;
      o_d = (obs_data.size() != 0) ? obs_data.pop_front() : 8'hxx;
      checks++; if (o_ack !== 4'(4'b0001 << e_id)) begin errors++; $display("FAIL single_ack got %b exp %b", o_ack, 4'(4'b0001 << e_id)); end
      checks++; if (o_gid !== 2'(e_id)) begin errors++; $display("FAIL single_grant_id got %0d exp %0d", o_gid, e_id); end
      checks++; if (o_d !== e_d) begin errors++; $display("FAIL single_tx_data got %h exp %h", o_d, e_d); end
    end
    checks++;
    if (obs_ack.size() != 0 || obs_data.size() != 0) begin
      errors++; $display("FAIL single_extra got acks=%0d starts=%0d exp 0", obs_ack.size(), obs_data.size());
    end
  endtask

  task automatic test_rotation();
    int e_id; logic [3:0] o_ack; logic [1:0] o_gid; logic [7:0] e_d, o_d; bit to;
    apply_reset();
    drop_a = 1'b0; data_a = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      exp_id.push_back(k % 4); exp_data.push_back(8'h10 + 8'(k % 4));
    end
    req_a = 4'b1111;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (obs_data.size() >= 5) begin to = 1'b0; break; end
    end
    req_a = 4'b0000;
    for (int i = 0; i < 100 && active_a; i++) tick();
    checks++;
    if (to || active_a) begin errors++; $display("FAIL rotation_wait got timeout exp 5 launches then idle"); end
    while (exp_id.size() != 0) begin
      e_id = exp_id.pop_front(); e_d = exp_data.pop_front();
      o_ack = (obs_ack.size() != 0) ? obs_ack.pop_front() : 4'h0;
      o_gid = (obs_gid.size() != 0) ? obs_gid.pop_front() : 2'bxx;
      o_d = (obs_data.size() != 0) ? obs_data.pop_front() : 8'hxx;
      checks++; if (o_ack !== 4'(4'b0001 << e_id)) begin errors++; $display("FAIL rotation_ack got %b exp %b", o_ack, 4'(4'b0001 << e_id)); end
      checks++; if (o_gid !== 2'(e_id)) begin errors++; $display("FAIL rotation_grant_id got %0d exp %0d", o_gid, e_id); end
      checks++; if (o_d !== e_d) begin errors++; $display("FAIL rotation_tx_data got %h exp %h", o_d, e_d); end
    end
    checks++;
    if (obs_ack.size() != 0) begin errors++; $display("FAIL rotation_extra got %0d acks exp 0", obs_ack.size()); end
  endtask

  task automatic test_wrap();
    int e_id; logic [3:0] o_ack; logic [1:0] o_gid; logic [7:0] e_d, o_d; bit to;
    apply_reset();
    drop_a = 1'b1; data_a = 32'hD300_00D0;
    exp_id.push_back(3); exp_data.push_back(8'hD3);
    req_a = 4'b1000;
    for (int i = 0; i < 20 && obs_ack.size() == 0; i++) tick();
    exp_id.push_back(0); exp_data.push_back(8'hD0);
    exp_id.push_back(3); exp_data.push_back(8'hD3);
    req_a = 4'b1001;
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (obs_data.size() >= 3 && !active_a) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin errors++; $display("FAIL wrap_wait got timeout exp 3 transfers"); end
    while (exp_id.size() != 0) begin
      e_id = exp_id.pop_front(); e_d = exp_data.pop_front();
      o_ack = (obs_ack.size() != 0) ? obs_ack.pop_front() : 4'h0;
      o_gid = (obs_gid.size() != 0) ? obs_gid.pop_front() : 2'bxx;
      o_d = (obs_data.size() != 0) ? obs_data.pop_front() : 8'hxx;
      checks++; if (o_ack !== 4'(4'b0001 << e_id)) begin errors++; $display("FAIL wrap_ack got %b exp %b", o_ack, 4'(4'b0001 << e_id)); end
      checks++; if (o_gid !== 2'(e_id)) begin errors++; $display("FAIL wrap_grant_id got %0d exp %0d", o_gid, e_id); end
      checks++; if (o_d !== e_d) begin errors++; $display("FAIL wrap_tx_data got %h exp %h", o_d, e_d); end
    end
  endtask

  task automatic test_timeout();
    int e_id, ss; logic [3:0] o_ack; logic [1:0] o_gid; logic [7:0] e_d, o_d; bit to;
    apply_reset();
    model_en_a = 1'b0; drop_a = 1'b1; data_a = 32'h0000_005A;
    exp_id.push_back(0); exp_data.push_back(8'h5A);
    req_a = 4'b0001;
    to = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (err_cnt >= 1) begin to = 1'b0; break; end
    end
    for (int i = 0; i < 50 && active_a; i++) tick();
    repeat (5) tick();
    checks++;
    if (to) begin errors++; $display("FAIL timeout_wait got timeout exp err_timeout pulse"); end
    ss = (obs_start_cyc.size() != 0) ? obs_start_cyc[0] : -5000;
    checks++;
    if (err_cyc - ss != 1024) begin errors++; $display("FAIL timeout_latency got %0d exp 1024", err_cyc - ss); end
    checks++;
    if (act_fall_a - err_cyc != 16) begin errors++; $display("FAIL timeout_gap got %0d exp 16", act_fall_a - err_cyc); end
    model_en_a = 1'b1; data_a = 32'h00C3_0000;
    exp_id.push_back(2); exp_data.push_back(8'hC3);
    req_a = 4'b0100;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (obs_data.size() >= 2 && !active_a) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin errors++; $display("FAIL timeout_recover_wait got timeout exp transfer"); end
    checks++;
    if (err_cnt != 1) begin errors++; $display("FAIL timeout_pulses got %0d exp 1", err_cnt); end
    while (exp_id.size() != 0) begin
      e_id = exp_id.pop_front(); e_d = exp_data.pop_front();
      o_ack = (obs_ack.size() != 0) ? obs_ack.pop_front() : 4'h0;
      o_gid = (obs_gid.size() != 0) ? obs_gid.pop_front() : 2'bxx;
      o_d = (obs_data.size() != 0) ? obs_data.pop_front() : 8'hxx;
      checks++; if (o_ack !== 4'(4'b0001 << e_id)) begin errors++; $display("FAIL timeout_ack got %b exp %b", o_ack, 4'(4'b0001 << e_id)); end
      checks++; if (o_gid !== 2'(e_id)) begin errors++; $display("FAIL timeout_grant_id got %0d exp %0d", o_gid, e_id); end
      checks++; if (o_d !== e_d) begin errors++; $display("FAIL timeout_tx_data got %h exp %h", o_d, e_d); end
    end
  endtask

  task automatic test_reset_mid();
    int e_id, c0, sa, ss; logic [3:0] o_ack; logic [1:0] o_gid; logic [7:0] e_d, o_d;
    apply_reset();
    drop_a = 1'b1; data_a = 32'h0077_0000;
    exp_id.push_back(2); exp_data.push_back(8'h77);
    req_a = 4'b0100;
    for (int i = 0; i < 50 && !tx_busy_a; i++) tick();
    repeat (5) tick();
    checks++;
    if (active_a !== 1'b1 || tx_busy_a !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre got active=%b busy=%b exp 1 1", active_a, tx_busy_a);
    end
    while (exp_id.size() != 0) begin
      e_id = exp_id.pop_front(); e_d = exp_data.pop_front();
      o_ack = (obs_ack.size() != 0) ? obs_ack.pop_front() : 4'h0;
      o_gid = (obs_gid.size() != 0) ? obs_gid.pop_front() : 2'bxx;
      o_d = (obs_data.size() != 0) ? obs_data.pop_front() : 8'hxx;
      checks++; if (o_ack !== 4'(4'b0001 << e_id)) begin errors++; $display("FAIL reset_mid_ack got %b exp %b", o_ack, 4'(4'b0001 << e_id)); end
      checks++; if (o_gid !== 2'(e_id)) begin errors++; $display("FAIL reset_mid_grant_id got %0d exp %0d", o_gid, e_id); end
      checks++; if (o_d !== e_d) begin errors++; $display("FAIL reset_mid_tx_data got %h exp %h", o_d, e_d); end
    end
    // Assert reset between edges and look before the next rising edge.
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ack_a, tx_start_a, tx_data_a, gid_a, active_a, err_a} !== 17'h0) begin
      errors++; $display("FAIL reset_mid_async got %h exp 0", {ack_a, tx_start_a, tx_data_a, gid_a, active_a, err_a});
    end
    tick();
    clear_obs();
    data_a = 32'h0000_0042;
    exp_id.push_back(0); exp_data.push_back(8'h42);
    reset = 1'b1; req_a = 4'b0001;
    c0 = cyc;
    for (int i = 0; i < 20 && obs_data.size() == 0; i++) tick();
    sa = (obs_ack_cyc.size() != 0) ? obs_ack_cyc[0] : -100;
    ss = (obs_start_cyc.size() != 0) ? obs_start_cyc[0] : -100;
    checks++;
    if (sa - c0 != 1) begin errors++; $display("FAIL reset_mid_ack_latency got %0d exp 1", sa - c0); end
    checks++;
    if (ss - c0 != 2) begin errors++; $display("FAIL reset_mid_start_latency got %0d exp 2", ss - c0); end
    for (int i = 0; i < 200 && active_a; i++) tick();
    while (exp_id.size() != 0) begin
      e_id = exp_id.pop_front(); e_d = exp_data.pop_front();
      o_ack = (obs_ack.size() != 0) ? obs_ack.pop_front() : 4'h0;
      o_d = (obs_data.size() != 0) ? obs_data.pop_front() : 8'hxx;
      checks++; if (o_ack !== 4'(4'b0001 << e_id)) begin errors++; $display("FAIL reset_mid_first_ack got %b exp %b", o_ack, 4'(4'b0001 << e_id)); end
      checks++; if (o_d !== e_d) begin errors++; $display("FAIL reset_mid_first_data got %h exp %h", o_d, e_d); end
    end
  endtask

  task automatic test_gap0();
    logic [3:0] exp_b[$]; logic [3:0] o_ack; int a1; bit to;
    apply_reset();
    drop_b = 1'b1; data_b = 32'h0000_2221;
    exp_b.push_back(4'b0001); exp_b.push_back(4'b0010);
    req_b = 4'b0011;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (obs_ack_b.size() >= 2) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin errors++; $display("FAIL gap0_wait got timeout exp 2 acks"); end
    checks++;
    if (tx_data_b !== 8'h22) begin errors++; $display("FAIL gap0_tx_data got %h exp 22", tx_data_b); end
    a1 = (obs_ack_cyc_b.size() >= 2) ? obs_ack_cyc_b[1] : -100;
    // Two edges after the DUT first samples tx_busy low (+1 for sampling).
    checks++;
    if (a1 - busy_fall_b != 3) begin errors++; $display("FAIL gap0_ack_spacing got %0d exp 3", a1 - busy_fall_b); end
    while (exp_b.size() != 0) begin
      o_ack = (obs_ack_b.size() != 0) ? obs_ack_b.pop_front() : 4'h0;
      checks++;
      if (o_ack !== exp_b[0]) begin errors++; $display("FAIL gap0_ack got %b exp %b", o_ack, exp_b[0]); end
      void'(exp_b.pop_front());
    end
    for (int i = 0; i < 100 && active_b; i++) tick();
    checks++;
    if (active_b !== 1'b0) begin errors++; $display("FAIL gap0_idle got %b exp 0", active_b); end
  endtask

  initial begin
    busy_prev_a = 1'b0; act_prev_a = 1'b0; busy_prev_b = 1'b0;
    clear_obs();
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_gap0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter (8N1, byte-wide `tx_data` plus a `tx_start` strobe and `tx_busy` status) between NUM_REQ byte sources, for example a loopback echo of received bytes, a status reporter and a debug console.
- Arbitrates round-robin, acknowledges the winning source, launches the transmitter and tracks it to completion.
- Enforces a configurable inter-frame gap between transmissions.
- Flags a transmitter that never reports busy after a launch.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk cycles inserted after tx_busy falls before the next arbitration (0 = no gap).
- BUSY_TIMEOUT, 1023, max clk cycles to wait for tx_busy to rise after tx_start before declaring an error.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- req  in  NUM_REQ  per-requester level request; held high with stable data until ack.
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- tx_start  out  1  one-cycle launch strobe to the transmitter.
- tx_data  out  8  byte presented to the transmitter; stable from launch until the next grant.
- tx_busy  in  1  transmitter busy (high from shortly after tx_start until the stop bit ends).
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- active  out  1  high whenever the state is not IDLE.
- err_timeout  out  1  one-cycle pulse when BUSY_TIMEOUT expires.

Behaviour:
- Reset (reset=0, async): state=IDLE, ack=0, tx_start=0, tx_data=0, grant_id=0, err_timeout=0, gap/timeout counters=0, rr pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if |req, pick the first set bit searching from (rr_ptr+1) mod NUM_REQ upward with wrap. On the same edge:
  - register grant_id and rr_ptr to the winner;
  - load tx_data from the winner's req_data slice;
  - assert ack[winner] for exactly one cycle;
  - go to LAUNCH.
  - If no req, stay in IDLE.
- LAUNCH: tx_start=1 for one cycle; clear the timeout counter; go to WAIT_BUSY.
  - Latency: req sampled at edge N gives ack high during cycle N+1 and tx_start high during cycle N+2.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Else, if the counter equals BUSY_TIMEOUT, pulse err_timeout and go to GAP.
  - Else, increment the counter.
- WAIT_DONE: stay while tx_busy=1. When tx_busy=0, go to GAP with the gap counter cleared.
- GAP: if GAP_CYCLES==0, go to IDLE on the next edge. Otherwise count to GAP_CYCLES-1, then go to IDLE. req is ignored during GAP.
- req is sampled only in IDLE. Requests arriving in other states wait, and no ack is issued.
- Requester contract: after ack it must drop req or present its next byte. A req still high one cycle after ack counts as a new request. Fairness is guaranteed because rr_ptr has moved past the winner.
- Simultaneous requests: all pending requesters are served before any one is served twice (rotation).
- req dropped before grant: no ack. Withdrawal is legal only while no ack has been seen.
- tx_busy already high in IDLE: ignored. Arbitration is gated only by state.
- Counter widths are $clog2(param+1). They never wrap, because comparison precedes increment.
- Reset mid-transmission aborts scheduling immediately. The transmitter has its own reset; no byte is replayed.

Decomposition:
- Shared package uart_pkg holds:
  - state localparams (3-bit encoding);
  - the default GAP_CYCLES and BUSY_TIMEOUT;
  - a function computing the counter width.
- Sub-module rr_arbiter (combinational): inputs req, rr_ptr; outputs grant_valid, grant_idx. Reusable for future RX-side routing.

Test Plan:
1. Single requester: req=4'b0010, req_data[15:8]=8'hA5; model tx_busy high 3 cycles after tx_start, for 20 cycles. Expected: ack=4'b0010 for one cycle; tx_start one cycle later; tx_data=8'hA5; grant_id=1; active falls GAP_CYCLES=16 cycles after tx_busy falls.
2. All four requesting continuously with bytes 8'h10/8'h11/8'h12/8'h13. Expected: tx_data sequence 10,11,12,13,10; ack order 0,1,2,3,0.
3. Requesters 3 and 0 assert together after a grant to 3. Expected: 0 is granted first, then 3, showing wrap of the rotation.
4. tx_busy held low after tx_start, with BUSY_TIMEOUT=1023. Expected: err_timeout pulses exactly once, 1024 cycles after LAUNCH; the block returns to IDLE after the gap; the next request is served normally.
5. Assert reset low in the middle of WAIT_DONE. Expected: outputs clear asynchronously, before the next clk edge. After release with req=4'b0001, the first grant goes to requester 0 and tx_start appears 2 cycles after req is sampled.
6. GAP_CYCLES=0 build, with two back-to-back requests. Expected: the second ack comes exactly 2 cycles after tx_busy falls (GAP→IDLE, then IDLE grant).
